// File: rtl/cic_rate_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cic_rate_ctrl_pkg
// Description : Shared radio definitions. It holds the rate codes used by the
//               decimator chain and the rate controller, the controller state
//               encoding, and a helper that sizes the shared down-counter.
// Revision    : 1.0 - initial release
// ============================================================================
package cic_rate_ctrl_pkg;

    // Rate codes. The decimator chain uses the same rate codes.
    localparam logic [1:0] c_RATE_48K  = 2'd0;
    localparam logic [1:0] c_RATE_96K  = 2'd1;
    localparam logic [1:0] c_RATE_192K = 2'd2;
    localparam logic [1:0] c_RATE_384K = 2'd3;

    // Rate controller state encoding
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_CLEAR  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    // Width needed to hold the largest of the three reload values
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_rate_counter.sv
`default_nettype none
// ============================================================================
// Module      : cic_rate_counter
// Description : Loadable down-counter with a zero flag. One instance is shared
//               by the flush, settle and drain-timeout counting.
// Ports       : clock    - rising-edge clock
//               reset_n  - synchronous active-low reset (clears the count)
//               i_load   - load i_value (this has priority over i_dec)
//               i_value  - reload value
//               i_dec    - decrement by one
//               o_count  - current count
//               o_zero   - count is zero
// Revision    : 1.0 - initial release
// ============================================================================
module cic_rate_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // The controller never asks for a decrement at zero, so no guard is needed.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/cic_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cic_rate_ctrl
// Description : Sample-rate change controller for the CIC decimator chain.
//               When a new rate is requested, the controller waits for an
//               output boundary (DRAIN). It then switches the rate and clears
//               the chain for a fixed number of clocks (CLEAR). It then
//               suppresses the first output strobes while the filter refills
//               (SETTLE) and returns to RUN.
// Ports       : clock          - rising-edge clock
//               reset_n        - synchronous active-low reset
//               rate_req       - requested rate code
//               rate_req_valid - request qualifier (used only when ready)
//               rate_req_ready - high in RUN
//               in_strobe      - ADC-rate sample strobe
//               cic_out_strobe - decimator output strobe
//               rate_sel       - active rate code to the decimator chain
//               cic_in_strobe  - gated input strobe to the chain
//               cic_clear      - synchronous clear of the chain
//               sample_valid   - qualified output strobe
//               busy           - high outside RUN
//               change_count   - completed rate changes (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module cic_rate_ctrl
    import cic_rate_ctrl_pkg::*;
#(
    parameter int RESET_RATE     = 0,
    parameter int FLUSH_CYCLES   = 16,
    parameter int SETTLE_OUTPUTS = 8,
    parameter int DRAIN_TIMEOUT  = 4096
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] rate_req,
    input  logic       rate_req_valid,
    output logic       rate_req_ready,
    input  logic       in_strobe,
    input  logic       cic_out_strobe,
    output logic [1:0] rate_sel,
    output logic       cic_in_strobe,
    output logic       cic_clear,
    output logic       sample_valid,
    output logic       busy,
    output logic [7:0] change_count
);

    localparam int               c_CNT_W      = cnt_width(FLUSH_CYCLES, SETTLE_OUTPUTS, DRAIN_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_FLUSH_LIM  = c_CNT_W'(FLUSH_CYCLES);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LIM = c_CNT_W'(SETTLE_OUTPUTS);
    localparam logic [c_CNT_W-1:0] c_DRAIN_LIM  = c_CNT_W'(DRAIN_TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [1:0]         c_RESET_RATE = 2'(RESET_RATE);

    state_t             r_state;
    state_t             w_next_state;
    logic [1:0]         r_rate_sel;
    logic [1:0]         r_pending;
    logic [7:0]         r_change_count;
    logic               r_entry;       // first clock in the current state
    logic               r_booted;      // the reset-time flush has completed

    logic               w_accept;
    logic               w_event;
    logic [c_CNT_W-1:0] w_limit;
    logic [c_CNT_W-1:0] w_rem;
    logic               w_rem_zero;
    logic               w_done;
    logic               w_cnt_load;
    logic               w_cnt_dec;
    logic [c_CNT_W-1:0] w_cnt_value;
    logic [c_CNT_W-1:0] w_cnt_count;
    logic               w_cnt_zero;

    // ------------------------------------------------------------------------
    // Shared counter. On the first clock of a state, the stored count is not
    // yet valid. That clock works from the state's limit and loads what is
    // left after its own event. This gives a fresh count on every entry,
    // including the entry forced by reset, which leaves the stored count at
    // zero.
    // ------------------------------------------------------------------------
    always_comb begin
        w_limit = '0;
        w_event = 1'b0;
        case (r_state)
            ST_DRAIN: begin
                w_limit = c_DRAIN_LIM;
                w_event = 1'b1;
            end
            ST_CLEAR: begin
                w_limit = c_FLUSH_LIM;
                w_event = 1'b1;
            end
            ST_SETTLE: begin
                w_limit = c_SETTLE_LIM;
                w_event = cic_out_strobe;
            end
            default: ;
        endcase
    end

    assign w_rem      = r_entry ? w_limit : w_cnt_count;
    assign w_rem_zero = r_entry ? (w_limit == '0) : w_cnt_zero;
    // Done either when nothing is left (zero-length limit) or when this
    // clock's event consumes the last unit.
    assign w_done     = w_rem_zero || (w_event && (w_rem == c_CNT_ONE));

    assign w_cnt_load  = r_entry;
    assign w_cnt_value = w_rem_zero ? '0 : (w_event ? (w_rem - c_CNT_ONE) : w_rem);
    assign w_cnt_dec   = !r_entry && w_event && !w_rem_zero;

    cic_rate_counter #(
        .WIDTH (c_CNT_W)
    ) u_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .i_load  (w_cnt_load),
        .i_value (w_cnt_value),
        .i_dec   (w_cnt_dec),
        .o_count (w_cnt_count),
        .o_zero  (w_cnt_zero)
    );

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_CLEAR;
            r_entry <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_entry <= (w_next_state != r_state);
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_RUN: begin
                // A request for the current rate is a no-op.
                if (rate_req_valid && (rate_req != r_rate_sel)) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cic_out_strobe || w_done) begin
                    w_next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (w_done) begin
                    w_next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_done) begin
                    w_next_state = ST_RUN;
                end
            end
            default: w_next_state = ST_CLEAR;
        endcase
    end

    // ------------------------------------------------------------------------
    // Rate registers and change counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_rate_sel     <= c_RESET_RATE;
            r_pending      <= c_RESET_RATE;
            r_change_count <= '0;
            r_booted       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pending <= rate_req;
            end
            // The new rate is presented to the chain from the first clock
            // of CLEAR.
            if ((r_state == ST_DRAIN) && (w_next_state == ST_CLEAR)) begin
                r_rate_sel <= r_pending;
            end
            // The first return to RUN after reset is the start-up flush.
            // It is not counted as a rate change.
            if ((r_state == ST_SETTLE) && (w_next_state == ST_RUN)) begin
                r_booted <= 1'b1;
                if (r_booted) begin
                    r_change_count <= r_change_count + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rate_req_ready = (r_state == ST_RUN);
    assign busy           = (r_state != ST_RUN);
    assign cic_clear      = (r_state == ST_CLEAR);
    assign cic_in_strobe  = in_strobe && (r_state != ST_CLEAR);
    assign sample_valid   = cic_out_strobe && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
    assign rate_sel       = r_rate_sel;
    assign change_count   = r_change_count;

endmodule
`default_nettype wire
